// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle one-bit-per-clock shifter for SLL/SRL/SRA and
// their variable-count forms. Loads the operand and count on a legal start,
// shifts once per clock, then pulses done with the final result.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   start    in   1   launch request, sampled only in IDLE
//   op       in   3   000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV
//   operand  in  32   value to shift
//   shamt    in   5   immediate shift count (ops 000-010)
//   rs_amt   in   5   register shift count (ops 011-101)
//   result   out 32   shift register contents, final while done=1
//   busy     out  1   high in any state other than IDLE
//   done     out  1   one-cycle completion pulse
//   err      out  1   one-cycle pulse for an illegal op at start
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rs_amt,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_result;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_W-1:0]     r_op;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_launch;
    logic                w_illegal;
    logic                w_op_legal;
    logic [CNT_W-1:0]    w_start_cnt;
    logic [DATA_W-1:0]   w_shifted;

    // Ops 110/111 are illegal; immediate forms take shamt, variable forms rs_amt.
    assign w_op_legal  = (op <= OP_W'(5));
    assign w_start_cnt = (op <= OP_W'(2)) ? shamt : rs_amt;

    // One-bit shift of the working register according to the latched op.
    always_comb begin
        w_shifted = r_result;
        case (r_op)
            3'd0, 3'd3: w_shifted = {r_result[DATA_W-2:0], 1'b0};
            3'd1, 3'd4: w_shifted = {1'b0, r_result[DATA_W-1:1]};
            3'd2, 3'd5: w_shifted = {r_result[DATA_W-1], r_result[DATA_W-1:1]};
            default:    w_shifted = r_result;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and launch/illegal decode.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_op_legal) begin
                        w_launch     = 1'b1;
                        w_next_state = (w_start_cnt != CNT_W'(0)) ? S_SHIFT : S_DONE;
                    end else begin
                        w_illegal    = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs; busy/done track the next state
    // so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err  <= w_illegal;
            r_busy <= (w_next_state != S_IDLE);
            r_done <= (w_next_state == S_DONE);
            if (w_launch) begin
                r_result <= operand;
                r_op     <= op;
                r_cnt    <= w_start_cnt;
            end else if (r_state == S_SHIFT) begin
                r_result <= w_shifted;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [4:0]  rs_amt;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        err;

    shift_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .rs_amt  (rs_amt),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [4:0]  rs_amt;
        logic [31:0] exp;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sb_t;

    vec_t vecs [10];
    sb_t  sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest expected launch.
    always @(posedge clk) begin
        #1;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1) begin
            sb_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL done_result: got 0x%08h expected 0x%08h", result, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic run_vec(input string name, input vec_t v);
        int busy_cnt;
        int err0;
        sb_t e;
        err0 = err_cnt;
        @(negedge clk);
        op = v.op; operand = v.operand; shamt = v.shamt; rs_amt = v.rs_amt;
        start = 1'b1;
        e.res = v.exp;
        e.cyc = cyc + 1 + v.n;
        sb.push_back(e);
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        op = 3'd7; operand = 32'h5A5A_5A5A; shamt = 5'd9; rs_amt = 5'd13;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            busy_cnt++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(v.n + 1));
        check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
        check({name, "_no_err"}, 32'(err_cnt - err0), 32'd0);
        sb.delete();
    endtask

    initial begin
        bit saw_busy;
        vec_t v;
        vecs[0] = '{3'd0, 32'h0000_0001, 5'd4,  5'd0,  32'h0000_0010, 4};
        vecs[1] = '{3'd5, 32'h8000_0000, 5'd0,  5'd31, 32'hFFFF_FFFF, 31};
        vecs[2] = '{3'd4, 32'h8000_0000, 5'd0,  5'd31, 32'h0000_0001, 31};
        vecs[3] = '{3'd4, 32'hDEAD_BEEF, 5'd7,  5'd0,  32'hDEAD_BEEF, 0};
        vecs[4] = '{3'd1, 32'hDEAD_BEEF, 5'd4,  5'd9,  32'h0DEA_DBEE, 4};
        vecs[5] = '{3'd3, 32'h0000_FFFF, 5'd3,  5'd16, 32'hFFFF_0000, 16};
        vecs[6] = '{3'd2, 32'h7FFF_FFF0, 5'd4,  5'd1,  32'h07FF_FFFF, 4};
        vecs[7] = '{3'd5, 32'hF000_0000, 5'd0,  5'd4,  32'hFF00_0000, 4};
        vecs[8] = '{3'd0, 32'h1234_5678, 5'd0,  5'd5,  32'h1234_5678, 0};
        vecs[9] = '{3'd2, 32'h8000_0001, 5'd1,  5'd0,  32'hC000_0000, 1};

        reset = 1'b0; start = 1'b0; op = 3'd0; operand = '0; shamt = '0; rs_amt = '0;
        #1;
        check("reset_result", result, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start pulses while busy (cycle 1 and the DONE cycle) must be ignored.
        begin
            sb_t e;
            @(negedge clk);
            op = 3'd0; operand = 32'h1; shamt = 5'd3; start = 1'b1;
            e.res = 32'h8; e.cyc = cyc + 1 + 3; sb.push_back(e);
            @(negedge clk); start = 1'b0;
            @(negedge clk); start = 1'b1; op = 3'd1; operand = 32'hFFFF_FFFF; shamt = 5'd1;
            @(negedge clk); start = 1'b0;
            @(negedge clk); start = 1'b1;
            check("busy_done_cycle", 32'(done), 32'd1);
            @(negedge clk); start = 1'b0;
            saw_busy = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (busy === 1'b1) saw_busy = 1'b1;
            end
            check("busy_no_relaunch", 32'(saw_busy), 32'd0);
            check("busy_sb_drained", 32'(sb.size()), 32'd0);
            check("busy_result_held", result, 32'h8);
            sb.delete();
        end

        // Illegal op: one-cycle err, nothing else moves.
        for (int k = 6; k < 8; k++) begin
            int err0;
            err0 = err_cnt;
            @(negedge clk);
            op = 3'(k); operand = 32'hAAAA_AAAA; shamt = 5'd2; rs_amt = 5'd2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("illegal%0d_err", k), 32'(err), 32'd1);
            check($sformatf("illegal%0d_busy", k), 32'(busy), 32'd0);
            check($sformatf("illegal%0d_done", k), 32'(done), 32'd0);
            check($sformatf("illegal%0d_result", k), result, 32'h8);
            @(negedge clk);
            check($sformatf("illegal%0d_err_fall", k), 32'(err), 32'd0);
            check($sformatf("illegal%0d_err_pulses", k), 32'(err_cnt - err0), 32'd1);
        end
        v = '{3'd0, 32'h1, 5'd1, 5'd0, 32'h2, 1};
        run_vec("after_illegal", v);

        // Asynchronous reset in the middle of a count-20 SRA.
        @(negedge clk);
        op = 3'd2; operand = 32'h8000_0000; shamt = 5'd20; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_result", result, 32'h0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        check("post_reset_idle", 32'(saw_busy), 32'd0);
        check("post_reset_result", result, 32'h0);
        v = '{3'd2, 32'h8000_0000, 5'd20, 5'd3, 32'hFFFF_F800, 20};
        run_vec("post_reset_sra", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
